// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle multiply/divide unit with architectural HI/LO registers.
//
// Ports:
//   clk       clock, all state on the rising edge
//   resetn    asynchronous active-low reset
//   in_valid  request present
//   in_ready  unit can accept this cycle (idle and not flushed)
//   op        0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (no-op)
//   opA       multiplicand / dividend / move source
//   opB       multiplier / divisor
//   flush     abort the in-flight op, block acceptance this cycle
//   busy      inverse of in_ready
//   done      one-cycle pulse, new HI/LO visible in the same cycle
//   hi, lo    HI and LO registers
//
// Multiply holds its latched operands for MUL_LAT cycles and writes the full product on the
// last one. Divide is restoring radix-2, MSB-first, one quotient bit per cycle on magnitudes,
// followed by a sign-fixup cycle.
module alu_muldiv #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDiv  = 2'd2;
    localparam logic [1:0] StFix  = 2'd3;

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    localparam int unsigned CntMax = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int unsigned CntW   = $clog2(CntMax);

    logic [1:0]         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;      // raw opA: multiplicand, or dividend for div-by-zero
    logic [WIDTH-1:0]   b_q, b_d;      // raw opB for multiply, divisor magnitude for divide
    logic               sgn_q, sgn_d;  // signed multiply
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;  // dividend bits shift out the top, quotient bits in
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               accept;
    logic               div_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] ext_a, ext_b, product;
    logic [WIDTH:0]     rem_shift;
    logic               sub_ok;

    assign in_ready = (state_q == StIdle) && !flush;
    assign busy     = !in_ready;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign accept   = in_valid && in_ready;

    // Magnitudes stay WIDTH-bit unsigned, so negating INT_MIN yields 2^(WIDTH-1) exactly.
    assign div_signed = (op == OpDiv);
    assign mag_a      = (div_signed && opA[WIDTH-1]) ? -opA : opA;
    assign mag_b      = (div_signed && opB[WIDTH-1]) ? -opB : opB;

    assign ext_a   = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign ext_b   = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign product = ext_a * ext_b;

    // Partial remainder is always below the divisor, so the low WIDTH bits of the
    // wrapped subtraction are the exact new remainder.
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign sub_ok    = rem_shift >= {1'b0, b_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    case (op)
                        OpMult, OpMultu: begin
                            state_d = StMul;
                            cnt_d   = CntW'(MUL_LAT - 1);
                            a_d     = opA;
                            b_d     = opB;
                            sgn_d   = (op == OpMult);
                        end
                        OpDiv, OpDivu: begin
                            state_d = StDiv;
                            cnt_d   = CntW'(WIDTH - 1);
                            a_d     = opA;
                            b_d     = mag_b;
                            quo_d   = mag_a;
                            rem_d   = '0;
                            q_neg_d = div_signed && (opA[WIDTH-1] ^ opB[WIDTH-1]);
                            r_neg_d = div_signed && opA[WIDTH-1];
                        end
                        OpMthi: begin
                            hi_d   = opA;
                            done_d = 1'b1;
                        end
                        OpMtlo: begin
                            lo_d   = opA;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            StMul: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = product;
                    done_d       = 1'b1;
                    state_d      = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDiv: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    rem_d = sub_ok ? (rem_shift[WIDTH-1:0] - b_q) : rem_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], sub_ok};
                    if (cnt_q == '0) begin
                        state_d = StFix;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            StFix: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    if (b_q == '0) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = q_neg_q ? -quo_q : quo_q;
                        hi_d = r_neg_q ? -rem_q : rem_q;
                    end
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH = 32, MUL_LAT = 2).
module tb_alu_muldiv;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb_q[$];
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    alu_muldiv #(.WIDTH(32), .MUL_LAT(2)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .opA      (opA),
        .opB      (opB),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: native 64-bit arithmetic, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
        longint sa;
        longint sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: return 64'(sa * sb);
            3'd1: return {32'h0, a} * {32'h0, b};
            3'd2: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = 32'(sa / sb);
                r = 32'(sa % sb);
                return {r, q};
            end
            3'd3: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'd4: return {a, l};
            3'd5: return {h, a};
            default: return {h, l};
        endcase
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        int          exp_lat;
        int          lat;
        logic        busy_all;
        logic [63:0] e;
        exp_lat = (o >= 3'd4) ? 0 : ((o <= 3'd1) ? 2 : 33);
        e = model(o, a, b, m_hi, m_lo);
        sb_q.push_back(e);
        {m_hi, m_lo} = e;
        @(negedge clk);
        chk({tag, "_ready"}, {63'h0, in_ready}, 64'h1);
        in_valid = 1'b1;
        op       = o;
        opA      = a;
        opB      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opA      = $urandom;
        opB      = $urandom;
        op       = 3'(o + 3'd1);
        lat      = 0;
        busy_all = 1'b1;
        while (done !== 1'b1 && lat < 100) begin
            busy_all &= busy;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        if (exp_lat > 0) chk({tag, "_busy"}, {63'h0, busy_all}, 64'h1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_hilo"}, {hi, lo}, e);
        end
        chk({tag, "_ready_done"}, {63'h0, in_ready}, 64'h1);
        if (exp_lat > 0) begin
            @(posedge clk);
            #1;
            chk({tag, "_done_drop"}, {63'h0, done}, 64'h0);
        end
    endtask

    initial begin
        logic seen_done;
        resetn   = 1'b0;
        in_valid = 1'b0;
        op       = 3'd0;
        opA      = 32'h0;
        opB      = 32'h0;
        flush    = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("reset_hilo", {hi, lo}, 64'h0);
        chk("reset_done", {63'h0, done}, 64'h0);
        chk("reset_ready_busy", {62'h0, in_ready, busy}, 64'h2);

        do_op(3'd0, 32'hFFFF_FFFE, 32'd3, "mult");
        do_op(3'd1, 32'hFFFF_FFFE, 32'd3, "multu");
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        do_op(3'd3, 32'd7, 32'd2, "divu_7_2");
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        do_op(3'd3, 32'd5, 32'd0, "divu_by0");
        do_op(3'd2, 32'hFFFF_FFF7, 32'd0, "div_by0");
        do_op(3'd2, 32'd100, 32'hFFFF_FFF9, "div_100_m7");
        do_op(3'd4, 32'hCAFE_0001, 32'd0, "mthi");
        do_op(3'd5, 32'hBEEF_0002, 32'd0, "mtlo");

        // Reserved op: accepted, no done, HI/LO untouched.
        @(negedge clk);
        in_valid = 1'b1;
        op       = 3'd6;
        opA      = 32'h1111_1111;
        opB      = 32'h2222_2222;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        seen_done = 1'b0;
        repeat (3) begin
            seen_done |= done;
            @(posedge clk);
            #1;
        end
        chk("rsvd_done", {63'h0, seen_done}, 64'h0);
        chk("rsvd_hilo", {hi, lo}, {m_hi, m_lo});
        chk("rsvd_ready", {63'h0, in_ready}, 64'h1);

        // Flush in the tenth DIV cycle.
        do_op(3'd4, 32'h0000_1234, 32'd0, "pre_mthi");
        @(negedge clk);
        in_valid = 1'b1;
        op       = 3'd3;
        opA      = 32'd100;
        opB      = 32'd7;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        seen_done = done;
        repeat (9) begin
            @(posedge clk);
            #1;
            seen_done |= done;
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_blocks_ready", {63'h0, in_ready}, 64'h0);
        @(posedge clk);
        #1;
        seen_done |= done;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_ready_after", {63'h0, in_ready}, 64'h1);
        repeat (40) begin
            @(posedge clk);
            #1;
            seen_done |= done;
        end
        chk("flush_no_done", {63'h0, seen_done}, 64'h0);
        chk("flush_hilo_kept", {hi, lo}, {m_hi, m_lo});
        do_op(3'd1, 32'd3, 32'd4, "post_flush_multu");

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        in_valid = 1'b1;
        op       = 3'd1;
        opA      = 32'h0001_0000;
        opB      = 32'h0001_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("areset_hilo", {hi, lo}, 64'h0);
        chk("areset_done", {63'h0, done}, 64'h0);
        m_hi = 32'h0;
        m_lo = 32'h0;
        @(negedge clk);
        resetn    = 1'b1;
        seen_done = 1'b0;
        #1;
        chk("areset_ready_busy", {62'h0, in_ready, busy}, 64'h2);
        repeat (4) begin
            @(posedge clk);
            #1;
            seen_done |= done;
        end
        chk("areset_no_done", {63'h0, seen_done}, 64'h0);
        chk("areset_hilo_after", {hi, lo}, 64'h0);
        chk("sb_empty", 64'(sb_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
